// File: rtl/round_robin_dispatcher.sv
// Round-robin dispatcher: fans one valid/ready stream out to N one-entry output
// registers, skipping full ports and rotating priority past the port that was loaded.
module round_robin_dispatcher #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [N*W-1:0] out_data,
  output logic [N-1:0]   out_sel
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]   valid_q, valid_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [N*W-1:0] data_q, data_d;

  logic [N-1:0]   free, mask, masked, pick_m, pick_u, sel;
  logic [PW-1:0]  sel_idx;
  logic           accept;

  // A port draining this cycle counts as free so it can be refilled back-to-back.
  always_comb begin
    free = ~valid_q | out_ready;
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (PW'(i) >= ptr_q);
    end
    masked = free & mask;
    pick_m = masked & (~masked + ONE);
    pick_u = free & (~free + ONE);
    sel    = (|masked) ? pick_m : pick_u;
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) sel_idx = PW'(i);
    end
  end

  assign in_ready = |free;
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    if (accept) begin
      valid_d = valid_d | sel;
      for (int i = 0; i < N; i++) begin
        if (sel[i]) data_d[i*W +: W] = in_data;
      end
      ptr_d = (sel_idx == PW'(N - 1)) ? '0 : sel_idx + PW'(1);
      sel_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_round_robin_dispatcher.sv
// Directed and randomized checks of round_robin_dispatcher at N=2 and N=4.
module tb_round_robin_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        iv2 = 1'b0, ir2;
  logic [7:0]  id2 = '0;
  logic [1:0]  ov2, or2 = '0, os2;
  logic [15:0] od2;
  logic        iv4 = 1'b0, ir4;
  logic [7:0]  id4 = '0;
  logic [3:0]  ov4, or4 = '0, os4;
  logic [31:0] od4;

  int n_tests = 0;
  int n_fail  = 0;

  round_robin_dispatcher #(.N(2), .W(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_sel(os2)
  );

  round_robin_dispatcher #(.N(4), .W(8)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_sel(os4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iv2 = 1'b0;
    iv4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp2;
    logic [3:0] f4, m_valid, m_sel;
    logic [7:0] m_data [4];
    int         m_ptr, tgt;
    int         seq3 [6];

    do_reset();
    chk("rst_valid2", ov2, 0);
    chk("rst_sel2", os2, 0);
    chk("rst_data2", od2, 0);
    chk("rst_valid4", ov4, 0);
    chk("rst_sel4", os4, 0);
    chk("rst_data4", od4, 0);

    // 1: N=2, all ready, alternating ports
    or2 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      iv2 = 1'b1;
      id2 = 8'hA0 + 8'(k);
      #1 chk("t1_in_ready", ir2, 1);
      @(negedge clk);
      exp2 = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("t1_sel", os2, exp2);
      chk("t1_valid", ov2, exp2);
      chk("t1_data", (k % 2 == 0) ? od2[7:0] : od2[15:8], 8'hA0 + 8'(k));
    end
    iv2 = 1'b0;
    @(negedge clk);
    chk("t1_drain", ov2, 0);

    // 2: N=2 blocking, then refill of a draining port past ptr
    do_reset();
    or2 = 2'b00;
    iv2 = 1'b1;
    id2 = 8'hA0;
    @(negedge clk);
    id2 = 8'hA1;
    @(negedge clk);
    id2 = 8'hA2;
    #1 chk("t2_blocked_ready", ir2, 0);
    @(negedge clk);
    chk("t2_hold_valid", ov2, 2'b11);
    chk("t2_hold_data", od2, 16'hA1A0);
    chk("t2_hold_sel", os2, 2'b10);
    or2 = 2'b10;
    #1 chk("t2_unblock_ready", ir2, 1);
    @(negedge clk);
    chk("t2_refill_valid", ov2, 2'b11);
    chk("t2_refill_data", od2, 16'hA2A0);
    chk("t2_refill_sel", os2, 2'b10);
    or2 = 2'b11;
    id2 = 8'hB0;
    @(negedge clk);
    iv2 = 1'b0;
    chk("t2_ptr0_sel", os2, 2'b01);
    chk("t2_ptr0_data", od2[7:0], 8'hB0);
    chk("t2_ptr0_valid", ov2, 2'b01);

    // 3: N=4 with port2 stalled full
    do_reset();
    or4 = 4'b1011;
    iv4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      id4 = 8'h10 + 8'(k);
      @(negedge clk);
      chk("t3_fill_sel", os4, 4'b0001 << k);
    end
    seq3 = '{0, 1, 3, 0, 1, 3};
    for (int k = 0; k < 6; k++) begin
      id4 = 8'h20 + 8'(k);
      @(negedge clk);
      chk("t3_sel", os4, 4'b0001 << seq3[k]);
      chk("t3_data", od4[seq3[k]*8 +: 8], 8'h20 + 8'(k));
      chk("t3_port2_data", od4[23:16], 8'h12);
      chk("t3_port2_valid", ov4[2], 1);
    end
    iv4 = 1'b0;
    or4 = 4'b1111;
    @(negedge clk);

    // 4: N=4 spaced singles, wrap 3 -> 0
    do_reset();
    or4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      iv4 = 1'b1;
      id4 = 8'h30 + 8'(k);
      @(negedge clk);
      iv4 = 1'b0;
      chk("t4_sel", os4, 4'b0001 << (k % 4));
      chk("t4_data", od4[(k % 4)*8 +: 8], 8'h30 + 8'(k));
      @(negedge clk);
    end

    // 5: reset while ports full and input valid
    do_reset();
    or2 = 2'b00;
    iv2 = 1'b1;
    id2 = 8'hE0;
    @(negedge clk);
    id2 = 8'hE1;
    @(negedge clk);
    chk("t5_full", ov2, 2'b11);
    id2 = 8'hE2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_valid", ov2, 0);
    chk("t5_rst_sel", os2, 0);
    chk("t5_rst_data", od2, 0);
    id2 = 8'hE3;
    #1 chk("t5_ready", ir2, 1);
    @(negedge clk);
    iv2 = 1'b0;
    chk("t5_first_sel", os2, 2'b01);
    chk("t5_first_data", od2[7:0], 8'hE3);
    chk("t5_first_valid", ov2, 2'b01);

    // 6: random traffic against a per-port scoreboard
    do_reset();
    m_valid = '0;
    m_sel   = '0;
    m_ptr   = 0;
    for (int i = 0; i < 4; i++) m_data[i] = '0;
    for (int c = 0; c < 10000; c++) begin
      iv4 = ($urandom_range(0, 9) < 7);
      id4 = 8'($urandom);
      or4 = 4'($urandom);
      #1;
      f4 = ~m_valid | or4;
      chk("t6_in_ready", ir4, |f4);
      chk("t6_valid", ov4, m_valid);
      chk("t6_sel", os4, m_sel);
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i]) chk("t6_data", od4[i*8 +: 8], m_data[i]);
      end
      m_valid = m_valid & ~or4;
      if (iv4 && (|f4)) begin
        tgt = -1;
        for (int s = 0; s < 4; s++) begin
          if (tgt < 0 && f4[(m_ptr + s) % 4]) tgt = (m_ptr + s) % 4;
        end
        m_valid[tgt] = 1'b1;
        m_data[tgt]  = id4;
        m_ptr        = (tgt + 1) % 4;
        m_sel        = 4'b0001 << tgt;
      end
      @(negedge clk);
    end
    iv4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
